booth_ctrl_param: RTL and testbench
===================================

# booth_ctrl_param

Parametrised sequencer for the radix-4 Booth multiplier datapath in the multdiv unit. Accepts a start request, issues one load cycle, then steps through the multiplier's 3-bit Booth windows. For each window it emits add/subtract, ×2-shift, no-op and shift-enable controls, and pulses `done` when the product is complete. Generalises the fixed 32-bit controller to any even operand width and adds an unsigned mode, a start/busy handshake and an optional abort.

## Interface
- `WIDTH`, 32: operand width in bits; even, ≥4. `N_S = WIDTH/2` signed iterations, `N_U = WIDTH/2+1` unsigned iterations.
- `CW`, `$clog2(WIDTH/2+2)`: width of `count` (derived localparam).
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr_n`  in  1  reset, synchronous, active-low; sampled on the `clk` rising edge.
- `start`  in  1  start request; honoured only in IDLE.
- `is_signed`  in  1  operand mode; sampled with `start`.
- `in`  in  3  current Booth window {b[2i+1], b[2i], b[2i-1]} from the datapath shift register.
- `abort`  in  1  present only with `BOOTH_CTRL_ABORT_EN`.
- `load`  out  1  load multiplicand/multiplier into datapath; 1 cycle.
- `aos`  out  1  1 = subtract, 0 = add.
- `sm`  out  1  use 2×multiplicand.
- `nop`  out  1  no accumulate this cycle.
- `shift_en`  out  1  shift product/multiplier register right by 2.
- `busy`  out  1  high in LOAD, ITER and DONE.
- `done`  out  1  one-cycle completion pulse.
- `count`  out  CW  iterations completed.

## Operation
- States: IDLE, LOAD, ITER, DONE.
- IDLE: `start`=1 → LOAD; latch `is_signed`, `last = is_signed ? N_S-1 : N_U-1`.
- LOAD: `load`=1, `count`←0 → ITER.
- ITER: `shift_en`=1; decode `in`; `count`←`count`+1; if `count`==`last` → DONE.
- DONE: `done`=1 → IDLE.
- Decode, valid only in ITER:
  - 000, 111: `nop`=1, `aos`=0, `sm`=0.
  - 001, 010: add M.
  - 011: add 2M (`sm`=1).
  - 100: sub 2M (`aos`=1, `sm`=1).
  - 101, 110: sub M (`aos`=1).
- Outside ITER: `nop`=1, `aos`=0, `sm`=0, `shift_en`=0.
- `start` while `busy`: ignored; the in-flight operation is unaffected. `is_signed` changes during an operation have no effect.
- `count` holds its final value through DONE and IDLE until the next LOAD. It never exceeds `N_U`.
- Unsigned mode: the datapath zero-extends the multiplier by 2 bits, so the extra iteration sees window 000 or 001.

## Timing
- Reset (`clr_n`=0 at an edge): state IDLE, `count`=0, `load`=`aos`=`sm`=`shift_en`=`busy`=`done`=0, `nop`=1.
  - Reset in any state, including mid-ITER, takes priority over `start` and `abort`.
- Outputs are Moore, except `aos`/`sm`/`nop`, which are combinational from `in` during ITER.
- Cycle 0 = the cycle in which `start` is sampled high:
  - `load` in cycle 1.
  - `shift_en` in cycles 2 … N+1.
  - `done` in cycle N+2.
  - IDLE in cycle N+3.
- Back-to-back operation: `start` held high in cycle N+3 launches the next operation immediately.
- `busy` is high from cycle 1 through cycle N+2.

## Configuration
- `BOOTH_CTRL_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in LOAD or ITER → IDLE next cycle; no `done`; `count` holds.
  - `abort` in DONE or IDLE is ignored; `clr_n` has priority over `abort`.
- Undefined: no `abort` port; every started operation runs to `done`.

## Test plan
- Reset: `clr_n`=0 for 2 cycles mid-ITER → all outputs at reset values, `count`=0, `done` never pulses.
- WIDTH=32, `is_signed`=1, `start` in cycle 0 → `load` in cycle 1, 16 `shift_en` cycles (2–17), `done` in cycle 18, `count`=16.
- WIDTH=32, `is_signed`=0 → 17 `shift_en` cycles, `done` in cycle 19, `count`=17; WIDTH=8 signed → `done` in cycle 6, `count`=4.
- Sweep `in` 0–7 during ITER → (`aos`,`sm`,`nop`) = 001, 000, 000, 010, 110, 100, 100, 001.
- `start` pulsed in cycles 5 and 10 of a running WIDTH=8 operation → ignored, `done` still in cycle 6; `start` in cycle 7 → new `load` in cycle 8.
- With `BOOTH_CTRL_ABORT_EN`, `abort` in cycle 4 (WIDTH=32) → IDLE in cycle 5, `busy`=0, no `done`, `count`=2.

Source files
------------

// File: rtl/booth_ctrl_param_if.sv
// Handshake/control bundle between the multdiv datapath and the radix-4 Booth sequencer.
// Optional abort signal is present only when BOOTH_CTRL_ABORT_EN is defined.
interface booth_ctrl_param_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(WIDTH / 2 + 2);

    logic          start;
    logic          is_signed;
    logic [2:0]    in;
`ifdef BOOTH_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          load;
    logic          aos;
    logic          sm;
    logic          nop;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

`ifdef BOOTH_CTRL_ABORT_EN
    modport master (
        output start, is_signed, in, abort,
        input  load, aos, sm, nop, shift_en, busy, done, count
    );
    modport slave (
        input  start, is_signed, in, abort,
        output load, aos, sm, nop, shift_en, busy, done, count
    );
`else
    modport master (
        output start, is_signed, in,
        input  load, aos, sm, nop, shift_en, busy, done, count
    );
    modport slave (
        input  start, is_signed, in,
        output load, aos, sm, nop, shift_en, busy, done, count
    );
`endif
endinterface

// File: rtl/booth_ctrl_param.sv
// Radix-4 Booth sequencer for the multdiv multiplier datapath, any even WIDTH >= 4.
// Signed mode runs WIDTH/2 iterations, unsigned mode WIDTH/2+1 (zero-extended multiplier).
// Optional feature: define BOOTH_CTRL_ABORT_EN to add an abort input that cancels
// an operation in LOAD or ITER without a done pulse.
module booth_ctrl_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    booth_ctrl_param_if.slave bus
);
    localparam int unsigned CW     = $clog2(WIDTH / 2 + 2);
    localparam int unsigned N_S    = WIDTH / 2;
    localparam int unsigned N_U    = WIDTH / 2 + 1;
    localparam logic [CW-1:0] LAST_S = CW'(N_S - 1);
    localparam logic [CW-1:0] LAST_U = CW'(N_U - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state_q,  state_nxt;
    logic [CW-1:0] count_q,  count_nxt;
    logic [CW-1:0] last_q,   last_nxt;
    logic          load_q,   load_nxt;
    logic          shift_q,  shift_nxt;
    logic          busy_q,   busy_nxt;
    logic          done_q,   done_nxt;
    logic          abort_hit;
    logic          aos_c;
    logic          sm_c;
    logic          nop_c;

    // Abort request qualifier; only consulted from LOAD and ITER
`ifdef BOOTH_CTRL_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    // State, iteration counter and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            last_q  <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            last_q  <= last_nxt;
            load_q  <= load_nxt;
            shift_q <= shift_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state, counter update and next values of the registered outputs
    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        last_nxt  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_LOAD;
                    last_nxt  = bus.is_signed ? LAST_S : LAST_U;
                end
            end
            ST_LOAD: begin
                if (abort_hit) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = '0;
                    state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (abort_hit) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count_q + CW'(1);
                    if (count_q == last_q) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        load_nxt  = (state_nxt == ST_LOAD);
        shift_nxt = (state_nxt == ST_ITER);
        busy_nxt  = (state_nxt != ST_IDLE);
        done_nxt  = (state_nxt == ST_DONE);
    end

    // Booth window decode; forced to no-op outside ITER
    always_comb begin
        aos_c = 1'b0;
        sm_c  = 1'b0;
        nop_c = 1'b1;
        if (state_q == ST_ITER) begin
            nop_c = 1'b0;
            case (bus.in)
                3'b000, 3'b111: nop_c = 1'b1;
                3'b001, 3'b010: begin end
                3'b011:         sm_c  = 1'b1;
                3'b100: begin
                    aos_c = 1'b1;
                    sm_c  = 1'b1;
                end
                3'b101, 3'b110: aos_c = 1'b1;
                default:        nop_c = 1'b1;
            endcase
        end
    end

    assign bus.load     = load_q;
    assign bus.shift_en = shift_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.aos      = aos_c;
    assign bus.sm       = sm_c;
    assign bus.nop      = nop_c;
endmodule

// File: tb/tb_booth_ctrl_param.sv
// Directed bench for booth_ctrl_param: WIDTH=32 and WIDTH=8 instances side by side.
// Abort scenario is exercised only when BOOTH_CTRL_ABORT_EN is defined.
module tb_booth_ctrl_param;
    logic       clk = 1'b0;
    logic       clr_n;
    logic       sel8;
    logic [2:0] in_v;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    booth_ctrl_param_if #(.WIDTH(32)) b32();
    booth_ctrl_param_if #(.WIDTH(8))  b8();

    booth_ctrl_param #(.WIDTH(32)) u32 (.clk(clk), .clr_n(clr_n), .bus(b32.slave));
    booth_ctrl_param #(.WIDTH(8))  u8  (.clk(clk), .clr_n(clr_n), .bus(b8.slave));

    logic       o_load, o_aos, o_sm, o_nop, o_shift, o_busy, o_done;
    logic [7:0] o_count;

    always_comb begin
        b32.in = in_v;
        b8.in  = in_v;
    end

    always_comb begin
        if (sel8) begin
            o_load  = b8.load;   o_aos  = b8.aos;  o_sm   = b8.sm;  o_nop = b8.nop;
            o_shift = b8.shift_en; o_busy = b8.busy; o_done = b8.done;
            o_count = 8'(b8.count);
        end else begin
            o_load  = b32.load;  o_aos  = b32.aos; o_sm   = b32.sm; o_nop = b32.nop;
            o_shift = b32.shift_en; o_busy = b32.busy; o_done = b32.done;
            o_count = 8'(b32.count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dec_exp(input int w);
        case (w)
            0: dec_exp = 3'b001;
            1: dec_exp = 3'b000;
            2: dec_exp = 3'b000;
            3: dec_exp = 3'b010;
            4: dec_exp = 3'b110;
            5: dec_exp = 3'b100;
            6: dec_exp = 3'b100;
            default: dec_exp = 3'b001;
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " load"},  32'(o_load),  32'd0);
        chk({tag, " shift"}, 32'(o_shift), 32'd0);
        chk({tag, " busy"},  32'(o_busy),  32'd0);
        chk({tag, " done"},  32'(o_done),  32'd0);
        chk({tag, " count"}, 32'(o_count), 32'd0);
        chk({tag, " asn"},   32'({o_aos, o_sm, o_nop}), 32'd1);
    endtask

    // One complete operation starting in cycle 0; n = expected iteration count
    task automatic run_op(input bit use8, input bit sgn, input int n, input bit sweep, input string tag);
        int load_n = 0, load_cyc = -1, shift_n = 0, first_sh = -1, last_sh = -1;
        int done_n = 0, done_cyc = -1, busy_bad = 0;
        logic [7:0] cnt_done = 8'hff;
        sel8 = use8;
        b8.is_signed  = sgn;
        b32.is_signed = sgn;
        for (int c = 0; c <= n + 5; c++) begin
            in_v = (sweep && c >= 2 && c <= 9) ? 3'(c - 2) : 3'b100;
            b8.start  = use8 && (c == 0);
            b32.start = !use8 && (c == 0);
            if (c == 3) begin
                b8.is_signed  = !sgn;
                b32.is_signed = !sgn;
            end
            #1;
            if (sweep && c >= 2 && c <= 9)
                chk($sformatf("%s decode in=%0d", tag, c - 2), 32'({o_aos, o_sm, o_nop}), 32'(dec_exp(c - 2)));
            if (c == 1)
                chk({tag, " decode in LOAD"}, 32'({o_aos, o_sm, o_nop}), 32'd1);
            if (o_load) begin load_n++; load_cyc = c; end
            if (o_shift) begin
                shift_n++;
                if (first_sh < 0) first_sh = c;
                last_sh = c;
            end
            if (o_done) begin done_n++; done_cyc = c; cnt_done = o_count; end
            if (o_busy !== ((c >= 1) && (c <= n + 2))) busy_bad++;
            if (c == n + 3) chk({tag, " count held in IDLE"}, 32'(o_count), 32'(n));
            tick();
        end
        chk({tag, " load pulses"},   32'(load_n),   32'd1);
        chk({tag, " load cycle"},    32'(load_cyc), 32'd1);
        chk({tag, " shift cycles"},  32'(shift_n),  32'(n));
        chk({tag, " first shift"},   32'(first_sh), 32'd2);
        chk({tag, " last shift"},    32'(last_sh),  32'(n + 1));
        chk({tag, " done pulses"},   32'(done_n),   32'd1);
        chk({tag, " done cycle"},    32'(done_cyc), 32'(n + 2));
        chk({tag, " count at done"}, 32'(cnt_done), 32'(n));
        chk({tag, " busy window"},   32'(busy_bad), 32'd0);
    endtask

    initial begin
        logic [31:0] load_mask;
        logic [31:0] done_mask;
        int          done_n;
        clr_n = 1'b0;
        sel8  = 1'b0;
        in_v  = 3'b100;
        b8.start = 1'b0;  b8.is_signed = 1'b1;
        b32.start = 1'b0; b32.is_signed = 1'b1;
`ifdef BOOTH_CTRL_ABORT_EN
        b8.abort = 1'b0;
        b32.abort = 1'b0;
`endif
        tick();
        tick();
        sel8 = 1'b0; #1; chk_reset("reset w32");
        sel8 = 1'b1; #1; chk_reset("reset w8");
        clr_n = 1'b1;
        tick();

        run_op(1'b0, 1'b1, 16, 1'b1, "s32");
        run_op(1'b0, 1'b0, 17, 1'b0, "u32");
        run_op(1'b1, 1'b1, 4,  1'b0, "s8");
        run_op(1'b1, 1'b0, 5,  1'b0, "u8");

        // start while busy is ignored; start in the IDLE cycle launches back-to-back
        sel8 = 1'b1;
        b8.is_signed = 1'b1;
        in_v = 3'b011;
        load_mask = '0;
        done_mask = '0;
        for (int c = 0; c <= 16; c++) begin
            b8.start = (c == 0) || (c == 5) || (c == 7) || (c == 10);
            #1;
            if (o_load) load_mask[c] = 1'b1;
            if (o_done) done_mask[c] = 1'b1;
            if (c == 7) chk("b2b busy in IDLE cycle", 32'(o_busy), 32'd0);
            tick();
        end
        b8.start = 1'b0;
        chk("b2b load cycles", load_mask, 32'h0000_0102);
        chk("b2b done cycles", done_mask, 32'h0000_2040);
        chk("b2b final count", 32'(o_count), 32'd4);

        // synchronous reset held two cycles in the middle of ITER
        sel8 = 1'b0;
        b32.is_signed = 1'b1;
        done_n = 0;
        for (int c = 0; c <= 30; c++) begin
            b32.start = (c == 0);
            clr_n = !((c == 6) || (c == 7));
            #1;
            if (o_done) done_n++;
            if (c == 6) chk("mid-ITER count before reset", 32'(o_count), 32'd4);
            if (c == 8) chk_reset("reset mid-ITER");
            tick();
        end
        clr_n = 1'b1;
        chk("reset mid-ITER no done", 32'(done_n), 32'd0);
        chk("reset mid-ITER count stays 0", 32'(o_count), 32'd0);

`ifdef BOOTH_CTRL_ABORT_EN
        // abort in ITER returns to IDLE without done and keeps count
        sel8 = 1'b0;
        done_n = 0;
        for (int c = 0; c <= 20; c++) begin
            b32.start = (c == 0);
            b32.abort = (c == 4);
            #1;
            if (o_done) done_n++;
            if (c == 5) begin
                chk("abort busy", 32'(o_busy), 32'd0);
                chk("abort shift_en", 32'(o_shift), 32'd0);
                chk("abort count", 32'(o_count), 32'd2);
            end
            tick();
        end
        b32.abort = 1'b0;
        chk("abort no done", 32'(done_n), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
